// File: rtl/de_selector_scan.sv
// Registered 1-to-CH demultiplexer with manual and prescaled scan channel selection.
// Optional build macro DE_SEL_HOLD_EN: unselected channels hold instead of idling at all-ones.
module de_selector_scan #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CH       = 4,
    parameter int unsigned SELW     = 2,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iEn,
    input  logic                  iMode,
    input  logic [SELW-1:0]       iS,
    input  logic [WIDTH-1:0]      iC,
    output logic [CH*WIDTH-1:0]   oZ,
    output logic [SELW-1:0]       oSel,
    output logic                  oWrap,
    output logic                  oErr
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [SELW-1:0] LAST_CH    = SELW'(CH - 1);
    localparam logic [SELW:0]   CH_LIMIT   = (SELW + 1)'(CH);

    typedef enum logic {StManual, StScan} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [SELW-1:0]      sel_q, sel_d;
    logic [CH*WIDTH-1:0]  z_q, z_d;
    logic                 wrap_q, wrap_d;
    logic                 err_q, err_d;
    logic                 route_en;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        sel_d    = sel_q;
        z_d      = z_q;
        wrap_d   = 1'b0;
        err_d    = err_q;
        route_en = 1'b0;

        if (iEn) begin
            if (iMode && state_q == StManual) begin
                state_d  = StScan;
                presc_d  = '0;
                sel_d    = '0;
                err_d    = 1'b0;
                route_en = 1'b1;
            end else if (iMode) begin
                err_d    = 1'b0;
                route_en = 1'b1;
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (sel_q == LAST_CH) begin
                        sel_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end else begin
                // Leaving scan also lands here, so a mode change beats a terminal count.
                state_d  = StManual;
                presc_d  = '0;
                sel_d    = iS;
                err_d    = ({1'b0, iS} >= CH_LIMIT);
                route_en = ({1'b0, iS} < CH_LIMIT);
            end

`ifdef DE_SEL_HOLD_EN
            z_d = z_q;
`else
            z_d = '1;
`endif
            for (int unsigned k = 0; k < CH; k++) begin
                if (route_en && sel_d == SELW'(k)) begin
                    z_d[k*WIDTH +: WIDTH] = iC;
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= StManual;
            presc_q <= '0;
            sel_q   <= '0;
            z_q     <= '1;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sel_q   <= sel_d;
            z_q     <= z_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign oZ    = z_q;
    assign oSel  = sel_q;
    assign oWrap = wrap_q;
    assign oErr  = err_q;

endmodule

// File: tb/tb_de_selector_scan.sv
// Bench for de_selector_scan: a CH=4/SCAN_DIV=4 and a CH=3/SCAN_DIV=1 instance share stimulus
// and are compared every cycle against a count-based model, plus directed literal checks.
module tb_de_selector_scan;

    logic       clk = 1'b0;
    logic       rst, en, mode, c;
    logic [1:0] s;

    logic [3:0] z4;
    logic [1:0] sel4;
    logic       wrap4, err4;
    logic [2:0] z3;
    logic [1:0] sel3;
    logic       wrap3, err3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    de_selector_scan #(.WIDTH(1), .CH(4), .SELW(2), .SCAN_DIV(4)) u_dut4 (
        .iClk(clk), .iRst(rst), .iEn(en), .iMode(mode), .iS(s), .iC(c),
        .oZ(z4), .oSel(sel4), .oWrap(wrap4), .oErr(err4)
    );

    de_selector_scan #(.WIDTH(1), .CH(3), .SELW(2), .SCAN_DIV(1)) u_dut3 (
        .iClk(clk), .iRst(rst), .iEn(en), .iMode(mode), .iS(s), .iC(c),
        .oZ(z3), .oSel(sel3), .oWrap(wrap3), .oErr(err3)
    );

    // Scan position is derived from the number of enabled scan edges since entering scan.
    typedef struct {
        bit          scan;
        int          cnt;
        logic [15:0] z;
        logic [1:0]  sel;
        logic        wrap;
        logic        err;
    } model_t;

    model_t m4, m3;
    bit     mvalid = 1'b0;

    function automatic model_t step_model(model_t m, int ch, int div);
        model_t      r;
        logic [15:0] base;
        int          k;
        r = m;
        if (rst) begin
            r.scan = 1'b0;
            r.cnt  = 0;
            r.z    = (16'd1 << ch) - 16'd1;
            r.sel  = 2'd0;
            r.wrap = 1'b0;
            r.err  = 1'b0;
            return r;
        end
        r.wrap = 1'b0;
        if (!en) return r;
`ifdef DE_SEL_HOLD_EN
        base = m.z;
`else
        base = (16'd1 << ch) - 16'd1;
`endif
        if (mode) begin
            if (m.scan) r.cnt = m.cnt + 1;
            else begin
                r.scan = 1'b1;
                r.cnt  = 0;
            end
            k      = (r.cnt / div) % ch;
            r.sel  = 2'(k);
            r.err  = 1'b0;
            r.wrap = (r.cnt > 0) && (r.cnt % (div * ch) == 0);
            r.z    = base;
            r.z[k] = c;
        end else begin
            r.scan = 1'b0;
            r.sel  = s;
            r.err  = (int'(s) >= ch);
            r.z    = base;
            if (!r.err) r.z[s] = c;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m4 <= step_model(m4, 4, 4);
        m3 <= step_model(m3, 3, 1);
        if (rst) mvalid <= 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("model_z4", 32'(z4), 32'(m4.z[3:0]));
            check("model_sel4", 32'(sel4), 32'(m4.sel));
            check("model_wrap4", 32'(wrap4), 32'(m4.wrap));
            check("model_err4", 32'(err4), 32'(m4.err));
            check("model_z3", 32'(z3), 32'(m3.z[2:0]));
            check("model_sel3", 32'(sel3), 32'(m3.sel));
            check("model_wrap3", 32'(wrap3), 32'(m3.wrap));
            check("model_err3", 32'(err3), 32'(m3.err));
        end
    end

    task automatic cyc(input logic r, input logic e, input logic md, input logic [1:0] ss,
                       input logic cc);
        rst  = r;
        en   = e;
        mode = md;
        s    = ss;
        c    = cc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic md;

        // Reset with iC=1, iMode=1
        cyc(1, 1, 1, 0, 1);
        cyc(1, 1, 1, 0, 1);
        check("rst_z4", 32'(z4), 32'h0f);
        check("rst_sel4", 32'(sel4), 32'h0);
        check("rst_wrap4", 32'(wrap4), 32'h0);
        check("rst_err4", 32'(err4), 32'h0);
        check("rst_z3", 32'(z3), 32'h7);

        // Manual routing
        cyc(0, 1, 0, 2, 0);
        check("man_z4", 32'(z4), 32'hb);
        check("man_sel4", 32'(sel4), 32'h2);
        check("man_z3", 32'(z3), 32'h3);
        cyc(0, 1, 0, 2, 1);
        check("man_c1_z4", 32'(z4), 32'hf);

        // Out-of-range on the CH=3 instance
        cyc(0, 1, 0, 3, 0);
        check("oor_z3", 32'(z3), 32'h7);
        check("oor_err3", 32'(err3), 32'h1);
        check("oor_sel3", 32'(sel3), 32'h3);
        check("oor_z4", 32'(z4), 32'h7);
        check("oor_err4", 32'(err4), 32'h0);
        cyc(0, 1, 0, 1, 0);
        check("oor_clr_err3", 32'(err3), 32'h0);
        check("oor_clr_z3", 32'(z3), 32'h5);

        // Scan sequencing
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 1, 0, 0);
            check("scan_sel", 32'(sel4), 32'((i - 1) / 4));
            check("scan_wrap", 32'(wrap4), 32'h0);
`ifndef DE_SEL_HOLD_EN
            check("scan_z", 32'(z4), 32'(~(4'b0001 << ((i - 1) / 4)) & 4'hf));
`endif
        end
        cyc(0, 1, 1, 0, 0);
        check("wrap_sel", 32'(sel4), 32'h0);
        check("wrap_pulse", 32'(wrap4), 32'h1);
        cyc(0, 1, 1, 0, 0);
        check("wrap_one_cycle", 32'(wrap4), 32'h0);

        // Enable drop mid-scan: scan count is 17 here, move to 21 (sel 1, prescaler 1)
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 3, 1);
            check("en0_sel", 32'(sel4), 32'h1);
            check("en0_wrap", 32'(wrap4), 32'h0);
        end
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        check("resume_sel_a", 32'(sel4), 32'h1);
        cyc(0, 1, 1, 0, 0);
        check("resume_sel_b", 32'(sel4), 32'h2);

        // Mode change on terminal count at the last channel: count 24 -> 31
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0, 0);
        check("term_sel", 32'(sel4), 32'h3);
        cyc(0, 1, 0, 1, 0);
        check("mchg_sel", 32'(sel4), 32'h1);
        check("mchg_wrap", 32'(wrap4), 32'h0);
`ifndef DE_SEL_HOLD_EN
        check("mchg_z", 32'(z4), 32'hd);
`endif

        // Reset mid-scan at channel 2
        for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0);
        check("pre_rst_sel", 32'(sel4), 32'h2);
        cyc(1, 1, 1, 0, 0);
        check("midrst_sel", 32'(sel4), 32'h0);
        check("midrst_z", 32'(z4), 32'hf);

        // Hold-feature distinction
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
`ifdef DE_SEL_HOLD_EN
        check("hold_z", 32'(z4), 32'hc);
`else
        check("hold_z", 32'(z4), 32'hd);
`endif

        // Randomized phase, checked by the model process
        md = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) md = ~md;
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 8), md,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/de_selector_scan.md
Name: de_selector_scan

Overview:
- Parametrised, registered 1-to-CH demultiplexer with WIDTH-bit data and active-low idle convention: unselected channels drive all-ones.
- Two modes:
  - manual: the channel comes from iS.
  - scan: an internal prescaled counter rotates through channels. Used for multiplexed digit/LED scanning.
- Successor to the combinational 1-to-4 selector. Adds registered outputs, a scan sequencer and out-of-range detection.

Parameters:
- WIDTH, 1: data width per channel.
- CH, 4: number of output channels, 2..16.
- SELW, 2: select width; must satisfy 2**SELW >= CH.
- SCAN_DIV, 4: clock cycles per channel in scan mode, >= 1.

Ports:
- iClk  input  1  clock, rising edge.
- iRst  input  1  synchronous reset, active-high.
- iEn  input  1  update enable; when 0, all registers hold.
- iMode  input  1  0 = manual, 1 = scan.
- iS  input  SELW  manual channel select.
- iC  input  WIDTH  data to route.
- oZ  output  CH*WIDTH  channel outputs; channel k occupies bits [k*WIDTH +: WIDTH].
- oSel  output  SELW  channel currently driven.
- oWrap  output  1  one-cycle pulse when scan wraps from CH-1 to 0.
- oErr  output  1  registered flag: manual select out of range.

Behaviour:
- Reset (iRst=1 at a clock edge), applied regardless of iEn; overrides any in-progress scan:
  - oZ = all ones; oSel = 0; oWrap = 0; oErr = 0.
  - Prescaler = 0; state = MANUAL.
- Output latency: all outputs are registered with 1-cycle latency. oZ reflects the iC and channel present at the previous edge.
- Routing: for the active channel ch, oZ[ch] <= iC. Every other channel <= {WIDTH{1'b1}}.
- State machine (evaluated only when iEn=1):
  - MANUAL -> SCAN when iMode=1. On entry, channel = 0 and prescaler = 0.
  - SCAN -> MANUAL when iMode=0. Channel follows iS from that same edge.
- MANUAL:
  - Channel = iS.
  - If iS >= CH: all oZ = ones, oErr = 1, oSel = iS.
  - Otherwise oErr = 0.
  - oWrap stays 0.
- SCAN:
  - Prescaler counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the prescaler returns to 0 and channel advances by 1. After CH-1 it wraps to 0.
  - On that wrap edge, oWrap = 1 for exactly one cycle.
  - iS is ignored; oErr = 0.
  - SCAN_DIV=1 advances the channel every enabled cycle.
- iEn=0:
  - oZ, oSel, state and prescaler hold.
  - oWrap is forced to 0.
  - oErr holds.
- Simultaneous events:
  - iRst beats everything.
  - A mode change and a prescaler terminal count on the same edge: the mode change wins; no advance, no oWrap.
- Width rule: channel and prescaler counters never exceed their range. The prescaler width is clog2(SCAN_DIV), minimum 1.

Optional Feature:
- Macro: DE_SEL_HOLD_EN.
- Defined: unselected channels hold their last registered value instead of being forced to all-ones. The selected channel still loads iC. Reset still sets all-ones. Out-of-range manual select holds all channels.
- Undefined: unselected channels are forced to all-ones, as specified above.

Test Plan:
- Reset: apply iRst for 2 cycles with iC=1, iMode=1 -> oZ=4'b1111, oSel=0, oWrap=0, oErr=0 (WIDTH=1, CH=4).
- Manual routing: iMode=0, iS=2, iC=0 -> one edge later oZ=4'b1011, oSel=2. Set iC=1 -> oZ=4'b1111.
- Out-of-range (CH=3, SELW=2): iS=3, iC=0 -> oZ=3'b111, oErr=1, oSel=3. iS=1 -> oErr=0, oZ=3'b101.
- Scan sequencing (SCAN_DIV=4, CH=4, iC=0, iMode=1 from cycle 0):
  - oSel = 0,0,0,0,1,1,1,1,2,...,3 across cycles 1-16.
  - oWrap=1 only on the cycle oSel returns to 0 (cycle 17). Active channel's oZ bit = 0.
- Enable/mode edge cases:
  - Drop iEn for 3 cycles mid-scan -> oSel and prescaler frozen, oWrap=0. Scan resumes on the same count.
  - Switch iMode to 0 on a terminal count -> no oWrap; oSel=iS next cycle.
  - Assert iRst mid-scan at oSel=2 -> oSel=0, oZ=all ones.
- DE_SEL_HOLD_EN build: manual iS=0 with iC=0, then iS=1 with iC=0 -> oZ=4'b1100 (channel 0 held low). Without the macro -> oZ=4'b1101.
